// File: rtl/ec413_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : ec413_pkg                                                  |
// | Description : Shared register-file geometry and dumper state encoding.  |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
package ec413_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int REG_DATA_W = 32;
    localparam int NUM_REGS   = 32;

    typedef logic [2:0] dump_state_t;

    localparam dump_state_t c_st_idle   = 3'd0;
    localparam dump_state_t c_st_fetch  = 3'd1;
    localparam dump_state_t c_st_drain0 = 3'd2;
    localparam dump_state_t c_st_drain1 = 3'd3;
    localparam dump_state_t c_st_done   = 3'd4;

endpackage
`default_nettype wire

// File: rtl/regfile_dumper.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : regfile_dumper                                             |
// | Description : Sweeps a register range through both read ports and       |
// |               streams one register per valid/ready beat.                |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module regfile_dumper
    import ec413_pkg::*;
#(
    parameter int ADDR_W    = REG_ADDR_W,
    parameter int DATA_W    = REG_DATA_W,
    parameter int FIRST_REG = 0,
    parameter int LAST_REG  = NUM_REGS - 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] rf_read_reg1,
    output logic [ADDR_W-1:0] rf_read_reg2,
    input  logic [DATA_W-1:0] rf_read_data1,
    input  logic [DATA_W-1:0] rf_read_data2,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_reg,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last
);

    localparam logic [ADDR_W-1:0] c_first = ADDR_W'(FIRST_REG);
    localparam logic [ADDR_W-1:0] c_last  = ADDR_W'(LAST_REG);

    dump_state_t       r_state;
    dump_state_t       w_state_next;
    logic [ADDR_W-1:0] r_idx;
    logic [ADDR_W-1:0] w_idx_p1;
    logic [DATA_W-1:0] r_buf0;
    logic [DATA_W-1:0] r_buf1;
    logic              w_last0;
    logic              w_last1;

    assign w_idx_p1 = r_idx + ADDR_W'(1);
    assign w_last0  = (r_idx == c_last);
    assign w_last1  = (w_idx_p1 == c_last);

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_st_idle:   if (start) w_state_next = c_st_fetch;
            c_st_fetch:  w_state_next = c_st_drain0;
            c_st_drain0: if (out_ready) w_state_next = w_last0 ? c_st_done : c_st_drain1;
            c_st_drain1: if (out_ready) w_state_next = w_last1 ? c_st_done : c_st_fetch;
            c_st_done:   w_state_next = c_st_idle;
            default:     w_state_next = c_st_idle;
        endcase
    end

    // Both read ports are captured together; the pair is replayed from these
    // buffers however long the consumer stalls.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_idx  <= c_first;
            r_buf0 <= '0;
            r_buf1 <= '0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (start) r_idx <= c_first;
                end
                c_st_fetch: begin
                    r_buf0 <= rf_read_data1;
                    r_buf1 <= rf_read_data2;
                end
                c_st_drain1: begin
                    if (out_ready && !w_last1) r_idx <= r_idx + ADDR_W'(2);
                end
                default: begin
                end
            endcase
        end
    end

    always_comb begin
        busy         = (r_state != c_st_idle);
        done         = 1'b0;
        rf_read_reg1 = '0;
        rf_read_reg2 = '0;
        out_valid    = 1'b0;
        out_reg      = '0;
        out_data     = '0;
        out_last     = 1'b0;
        case (r_state)
            c_st_fetch: begin
                rf_read_reg1 = r_idx;
                rf_read_reg2 = w_idx_p1;
            end
            c_st_drain0: begin
                out_valid = 1'b1;
                out_reg   = r_idx;
                out_data  = r_buf0;
                out_last  = w_last0;
            end
            c_st_drain1: begin
                out_valid = 1'b1;
                out_reg   = w_idx_p1;
                out_data  = r_buf1;
                out_last  = w_last1;
            end
            c_st_done: begin
                done = 1'b1;
            end
            default: begin
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_regfile_dumper.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_regfile_dumper                                          |
// | Description : Scoreboard bench for regfile_dumper (full and 3..7 range).|
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_regfile_dumper;

    typedef struct packed {
        logic [4:0]  r;
        logic [31:0] d;
        logic        l;
    } beat_t;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic [31:0] rf [32];

    logic        rst_a, start_a, ready_a, busy_a, done_a, valid_a, last_a;
    logic [4:0]  rr1_a, rr2_a, reg_a;
    logic [31:0] rd1_a, rd2_a, data_a;
    logic        rst_b, start_b, ready_b, busy_b, done_b, valid_b, last_b;
    logic [4:0]  rr1_b, rr2_b, reg_b;
    logic [31:0] rd1_b, rd2_b, data_b;

    assign rd1_a = rf[rr1_a];
    assign rd2_a = rf[rr2_a];
    assign rd1_b = rf[rr1_b];
    assign rd2_b = rf[rr2_b];

    regfile_dumper #(.ADDR_W(5), .DATA_W(32), .FIRST_REG(0), .LAST_REG(31)) dut_a (
        .clock(clock), .reset(rst_a), .start(start_a), .busy(busy_a), .done(done_a),
        .rf_read_reg1(rr1_a), .rf_read_reg2(rr2_a),
        .rf_read_data1(rd1_a), .rf_read_data2(rd2_a),
        .out_valid(valid_a), .out_ready(ready_a), .out_reg(reg_a),
        .out_data(data_a), .out_last(last_a)
    );

    regfile_dumper #(.ADDR_W(5), .DATA_W(32), .FIRST_REG(3), .LAST_REG(7)) dut_b (
        .clock(clock), .reset(rst_b), .start(start_b), .busy(busy_b), .done(done_b),
        .rf_read_reg1(rr1_b), .rf_read_reg2(rr2_b),
        .rf_read_data1(rd1_b), .rf_read_data2(rd2_b),
        .out_valid(valid_b), .out_ready(ready_b), .out_reg(reg_b),
        .out_data(data_b), .out_last(last_b)
    );

    logic sel;
    wire        m_valid = sel ? valid_b : valid_a;
    wire        m_ready = sel ? ready_b : ready_a;
    wire        m_busy  = sel ? busy_b  : busy_a;
    wire        m_done  = sel ? done_b  : done_a;
    wire        m_last  = sel ? last_b  : last_a;
    wire [4:0]  m_reg   = sel ? reg_b   : reg_a;
    wire [4:0]  m_rr1   = sel ? rr1_b   : rr1_a;
    wire [4:0]  m_rr2   = sel ? rr2_b   : rr2_a;
    wire [31:0] m_data  = sel ? data_b  : data_a;

    beat_t sb[$];
    int    n_cmp = 0;
    int    n_err = 0;
    int    cyc = 0;
    int    hs_count = 0;
    int    done_count = 0;
    int    last_hs_cyc = -10;
    int    fetch_cyc = 0;
    int    stall_left = 0;
    bit    throttle = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic rf_write(input int addr, input logic [31:0] val);
        if (addr != 0) rf[addr] = val;
    endtask

    task automatic push_range(input int first, input int last);
        for (int r = first; r <= last; r++) begin
            beat_t b;
            b.r = 5'(r);
            b.d = rf[r];
            b.l = (r == last);
            sb.push_back(b);
        end
    endtask

    // Every cycle a beat is shown it must equal the head of the scoreboard,
    // which also proves the outputs hold steady across a stall.
    task automatic monitor();
        if (m_valid) begin
            check("sb_empty_on_beat", 64'(sb.size() == 0), 64'd0);
            if (sb.size() != 0) check("beat", {m_reg, m_data, m_last}, sb[0]);
            if (m_ready) begin
                hs_count++;
                last_hs_cyc = cyc;
                if (sb.size() != 0) void'(sb.pop_front());
            end
        end
        if (m_done) begin
            done_count++;
            check("done_after_last", 64'(cyc), 64'(last_hs_cyc + 1));
        end
        cyc++;
    endtask

    task automatic tick();
        if (throttle) begin
            logic rdy;
            if (stall_left > 0) begin
                rdy = 1'b0;
                stall_left--;
            end else if ($urandom_range(0, 4) == 0) begin
                rdy = 1'b0;
                stall_left = ($urandom_range(0, 2) == 0) ? 9 : int'($urandom_range(0, 2));
            end else begin
                rdy = 1'b1;
            end
            ready_a = rdy;
            ready_b = rdy;
        end
        @(negedge clock);
        monitor();
        @(posedge clock);
        #1;
    endtask

    task automatic set_start(input logic v);
        if (sel) start_b = v;
        else     start_a = v;
    endtask

    task automatic run_dump(input logic s, input int first, input int last,
                            input bit extra_starts, input bit check_time);
        sel = s;
        sb.delete();
        push_range(first, last);
        hs_count = 0;
        done_count = 0;
        set_start(1'b1);
        tick();
        set_start(1'b0);
        fetch_cyc = cyc;
        check("fetch_busy",  64'(m_busy), 64'd1);
        check("fetch_valid", 64'(m_valid), 64'd0);
        check("fetch_rr1",   64'(m_rr1), 64'(first));
        check("fetch_rr2",   64'(m_rr2), 64'((first + 1) % 32));
        tick();
        check("first_valid", 64'(m_valid), 64'd1);
        for (int i = 0; i < 3000 && done_count == 0; i++) begin
            if (extra_starts && (i == 10 || i == 30)) set_start(1'b1);
            tick();
            set_start(1'b0);
        end
        check("dump_done",  64'(done_count), 64'd1);
        check("hs_count",   64'(hs_count), 64'(last - first + 1));
        check("sb_drained", 64'(sb.size()), 64'd0);
        if (check_time) check("full_dump_cycles", 64'(last_hs_cyc - fetch_cyc + 1), 64'd48);
        repeat (6) tick();
        check("idle_busy",      64'(m_busy), 64'd0);
        check("no_extra_beats", 64'(hs_count), 64'(last - first + 1));
        check("one_done",       64'(done_count), 64'd1);
    endtask

    initial begin
        bit found;
        for (int i = 0; i < 32; i++) rf[i] = 32'h0;
        sel = 1'b0;
        rst_a = 1'b1; start_a = 1'b0; ready_a = 1'b1;
        rst_b = 1'b1; start_b = 1'b0; ready_b = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        rst_a = 1'b0;
        rst_b = 1'b0;

        check("rst_busy",  64'(busy_a), 64'd0);
        check("rst_done",  64'(done_a), 64'd0);
        check("rst_valid", 64'(valid_a), 64'd0);
        check("rst_last",  64'(last_a), 64'd0);
        check("rst_reg",   64'(reg_a), 64'd0);
        check("rst_data",  64'(data_a), 64'd0);
        check("rst_rr1",   64'(rr1_a), 64'd0);
        check("rst_rr2",   64'(rr2_a), 64'd0);
        check("rst_b_valid", 64'(valid_b), 64'd0);

        rf_write(1, 32'h2);
        rf_write(3, 32'h5);
        rf_write(7, 32'h9);
        rf_write(5, 32'hA);
        rf_write(0, 32'h7);
        check("r0_reads_zero", 64'(rf[0]), 64'd0);

        // full unthrottled dump with start pulses while busy
        run_dump(1'b0, 0, 31, 1'b1, 1'b1);

        // throttled dump, opening with a 10-cycle stall
        throttle = 1'b1;
        stall_left = 10;
        run_dump(1'b0, 0, 31, 1'b0, 1'b0);
        throttle = 1'b0;
        ready_a = 1'b1;
        ready_b = 1'b1;

        // reset while r5 is presented from DRAIN1
        sel = 1'b0;
        sb.delete();
        push_range(0, 31);
        hs_count = 0;
        done_count = 0;
        found = 1'b0;
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            if (valid_a && reg_a == 5'd5) found = 1'b1;
            else tick();
        end
        check("r5_reached", 64'(found), 64'd1);
        ready_a = 1'b0;
        rst_a = 1'b1;
        tick();
        rst_a = 1'b0;
        ready_a = 1'b1;
        check("midrst_valid", 64'(valid_a), 64'd0);
        check("midrst_busy",  64'(busy_a), 64'd0);
        check("midrst_reg",   64'(reg_a), 64'd0);
        check("midrst_data",  64'(data_a), 64'd0);
        repeat (4) tick();
        check("midrst_no_done", 64'(done_count), 64'd0);
        check("midrst_hs",      64'(hs_count), 64'd5);
        run_dump(1'b0, 0, 31, 1'b0, 1'b1);

        // start coincident with reset
        start_a = 1'b1;
        rst_a = 1'b1;
        tick();
        start_a = 1'b0;
        rst_a = 1'b0;
        check("startrst_busy",  64'(busy_a), 64'd0);
        check("startrst_valid", 64'(valid_a), 64'd0);
        repeat (3) tick();
        check("startrst_idle",  64'(busy_a), 64'd0);

        // odd-length range 3..7
        run_dump(1'b1, 3, 7, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
